// File: rtl/tt_um_multi_digit_timer.sv
// Multi-digit BCD up/down timer with multiplexed seven-segment output.
// Run/step/clear controls, sticky wrap flag, one-hot digit scan.
`timescale 1ns/1ps
module tt_um_multi_digit_timer #(
    parameter int TICK_COUNT = 10_000_000,
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_COUNT = 10_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int PW = $clog2(TICK_COUNT);
    localparam int SW = (SCAN_COUNT > 1) ? $clog2(SCAN_COUNT) : 1;
    localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int NB = 4 * NUM_DIGITS;
    localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_COUNT - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_COUNT - 1);
    localparam logic [DW-1:0] SEL_LAST  = DW'(NUM_DIGITS - 1);

    logic [3:0]    sync1_q, sync2_q;
    logic          step_prev_q;
    logic [PW-1:0] pre_q, pre_d;
    logic [NB-1:0] dig_q, dig_d, ripple;
    logic          wrap_q, wrap_d;
    logic [SW-1:0] scan_q, scan_d;
    logic [DW-1:0] sel_q, sel_d;
    logic [7:0]    oh_q, oh_d;

    logic run, down, clr, step_rise, tick;
    logic all9, all0, carry;
    logic [3:0] cur;
    logic [6:0] seg;
    logic unused_ok;

    assign unused_ok = ^{uio_in, ui_in[7:4]};

    assign run       = sync2_q[0];
    assign down      = sync2_q[1];
    assign clr       = sync2_q[2];
    assign step_rise = sync2_q[3] & ~step_prev_q;
    assign tick      = ena & (run ? (pre_q == PRE_LAST) : step_rise);

    always_comb begin
        pre_d = pre_q;
        if (clr)
            pre_d = '0;
        else if (ena && run)
            pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
    end

    // Ripple chain: carry/borrow enters digit 0 and propagates upward.
    always_comb begin
        logic [3:0] d, nd;
        ripple = dig_q;
        carry  = 1'b1;
        all9   = 1'b1;
        all0   = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            d  = dig_q[4*i +: 4];
            nd = d;
            if (d != 4'd9) all9 = 1'b0;
            if (d != 4'd0) all0 = 1'b0;
            if (carry) begin
                if (down) begin
                    nd    = (d == 4'd0 || d > 4'd9) ? 4'd9 : d - 4'd1;
                    carry = (d == 4'd0);
                end else begin
                    nd    = (d >= 4'd9) ? 4'd0 : d + 4'd1;
                    carry = (d >= 4'd9);
                end
            end
            ripple[4*i +: 4] = nd;
        end
    end

    always_comb begin
        dig_d  = dig_q;
        wrap_d = wrap_q;
        if (clr) begin
            dig_d  = '0;
            wrap_d = 1'b0;
        end else if (tick) begin
            dig_d  = ripple;
            wrap_d = wrap_q | (down ? all0 : all9);
        end
    end

    always_comb begin
        scan_d = scan_q;
        sel_d  = sel_q;
        if (ena) begin
            if (scan_q == SCAN_LAST) begin
                scan_d = '0;
                sel_d  = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
            end else begin
                scan_d = scan_q + 1'b1;
            end
        end
        oh_d = 8'h01 << sel_d;
    end

    always_comb begin
        cur = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (sel_q == DW'(i)) cur = dig_q[4*i +: 4];
    end

    always_comb begin
        case (cur)
            4'd0:    seg = 7'h3F;
            4'd1:    seg = 7'h06;
            4'd2:    seg = 7'h5B;
            4'd3:    seg = 7'h4F;
            4'd4:    seg = 7'h66;
            4'd5:    seg = 7'h6D;
            4'd6:    seg = 7'h7D;
            4'd7:    seg = 7'h07;
            4'd8:    seg = 7'h7F;
            4'd9:    seg = 7'h6F;
            default: seg = 7'h00;
        endcase
    end

    assign uo_out  = {wrap_q, seg};
    assign uio_out = oh_q;
    assign uio_oe  = 8'hFF;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            step_prev_q <= 1'b0;
            pre_q       <= '0;
            dig_q       <= '0;
            wrap_q      <= 1'b0;
            scan_q      <= '0;
            sel_q       <= '0;
            oh_q        <= 8'h01;
        end else begin
            sync1_q     <= ui_in[3:0];
            sync2_q     <= sync1_q;
            step_prev_q <= sync2_q[3];
            pre_q       <= pre_d;
            dig_q       <= dig_d;
            wrap_q      <= wrap_d;
            scan_q      <= scan_d;
            sel_q       <= sel_d;
            oh_q        <= oh_d;
        end
    end

endmodule
